dbuf_ctrl: RTL

Write controller and arbiter for the DBUF data-buffer register in the 8051 SoC SFR block. It shares DBUF between two writers, the CPU SFR write path and a peripheral receive path, and drives DBUF's byte and operation inputs. It also tracks whether DBUF holds peripheral data the CPU has not yet read. It sits between the SFR decode logic and DBUF, and is the only block that drives DBUF's `i_op`/`i_byte`.

---
 rtl/dbuf_ctrl_if.sv | 33 +++
 rtl/dbuf_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/dbuf_ctrl_if.sv
// Request/ack and DBUF-drive signal bundle between SFR decode and dbuf_ctrl.
// Opcode width/encoding fall back to local defaults when Defines.v is absent.
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_DBUF_WR_BYTE
`define OP_DBUF_WR_BYTE 4'h6
`endif

interface dbuf_ctrl_if;
    logic                   i_cpu_req;
    logic [7:0]             i_cpu_byte;
    logic                   o_cpu_ack;
    logic                   i_per_req;
    logic [7:0]             i_per_byte;
    logic                   o_per_ack;
    logic                   i_cpu_rd;
    logic [7:0]             o_byte;
    logic [`SFR_OP_LEN-1:0] o_op;
    logic                   o_full;
    logic                   o_ovr;
    logic                   i_ovr_clr;

    modport slave (
        input  i_cpu_req, i_cpu_byte, i_per_req, i_per_byte, i_cpu_rd, i_ovr_clr,
        output o_cpu_ack, o_per_ack, o_byte, o_op, o_full, o_ovr
    );

    modport master (
        output i_cpu_req, i_cpu_byte, i_per_req, i_per_byte, i_cpu_rd, i_ovr_clr,
        input  o_cpu_ack, o_per_ack, o_byte, o_op, o_full, o_ovr
    );
endinterface

// File: rtl/dbuf_ctrl.sv
// DBUF write controller: round-robin arbiter between CPU and peripheral writers,
// plus unread-data (full) tracking. Overrun flag enabled by DBUF_CTRL_OVERRUN_EN.
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_DBUF_WR_BYTE
`define OP_DBUF_WR_BYTE 4'h6
`endif

module dbuf_ctrl (
    input logic        i_clk,
    input logic        i_rst,
    dbuf_ctrl_if.slave bus
);

    localparam logic [`SFR_OP_LEN-1:0] OpWr = `OP_DBUF_WR_BYTE;

    typedef enum logic {IDLE, WR} state_t;

    state_t     state_q, state_d;
    logic       lastPer_q, lastPer_d;
    logic       winPer_q, winPer_d;
    logic [7:0] byte_q, byte_d;
    logic       full_q, full_d;
    logic       cpuElig;
    logic       perElig;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            lastPer_q <= 1'b1;
            winPer_q  <= 1'b0;
            byte_q    <= 8'h00;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastPer_q <= lastPer_d;
            winPer_q  <= winPer_d;
            byte_q    <= byte_d;
            full_q    <= full_d;
        end
    end

    // A stalled peripheral stays ineligible while DBUF holds unread data,
    // unless overrun mode lets it overwrite.
    always_comb begin
        cpuElig = bus.i_cpu_req;
`ifdef DBUF_CTRL_OVERRUN_EN
        perElig = bus.i_per_req;
`else
        perElig = bus.i_per_req && !full_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        lastPer_d = lastPer_q;
        winPer_d  = winPer_q;
        byte_d    = byte_q;
        full_d    = full_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cpu_rd)
                    full_d = 1'b0;
                if (cpuElig || perElig) begin
                    winPer_d  = perElig && (!cpuElig || !lastPer_q);
                    lastPer_d = winPer_d;
                    byte_d    = winPer_d ? bus.i_per_byte : bus.i_cpu_byte;
                    state_d   = WR;
                end
            end
            WR: begin
                // New peripheral data wins over a coincident CPU read strobe.
                full_d  = winPer_q;
                state_d = IDLE;
            end
        endcase
    end

`ifdef DBUF_CTRL_OVERRUN_EN
    logic ovr_q, ovr_d;
    logic ovrSet;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            ovr_q <= 1'b0;
        else
            ovr_q <= ovr_d;
    end

    always_comb begin
        ovrSet = (state_q == WR) && winPer_q && full_q;
        ovr_d  = ovr_q;
        if (ovrSet)
            ovr_d = 1'b1;
        else if (bus.i_ovr_clr)
            ovr_d = 1'b0;
    end

    assign bus.o_ovr = ovr_q;
`else
    logic unusedOvrClr;
    assign unusedOvrClr = bus.i_ovr_clr;
    assign bus.o_ovr    = 1'b0;
`endif

    assign bus.o_op      = (state_q == WR) ? OpWr : '0;
    assign bus.o_byte    = (state_q == WR) ? byte_q : 8'h00;
    assign bus.o_cpu_ack = (state_q == WR) && !winPer_q;
    assign bus.o_per_ack = (state_q == WR) && winPer_q;
    assign bus.o_full    = full_q;

endmodule
